// File: rtl/apb_bridge_pkg.sv
// Shared types and constants for the APB3 initiator bridge.
package apb_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam int STATUS_W = 2;

    localparam logic [STATUS_W-1:0] ST_OK       = 2'b00;
    localparam logic [STATUS_W-1:0] ST_SLVERR   = 2'b01;
    localparam logic [STATUS_W-1:0] ST_TIMEOUT  = 2'b10;
    localparam logic [STATUS_W-1:0] ST_MISALIGN = 2'b11;

endpackage

// File: rtl/apb_wait_timer.sv
// Saturating wait-state counter; expired flags the enabled cycle whose
// increment brings the count up to a non-zero limit.
module apb_wait_timer #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         count_en,
    input  logic [W-1:0] limit,
    output logic         expired
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (count_en && (cnt_q != {W{1'b1}})) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    // A zero limit disables the abort entirely.
    assign expired = count_en && (limit != '0) && (cnt_q >= (limit - W'(1)));

endmodule

// File: rtl/apb_master_bridge.sv
// APB3 initiator: turns single core load/store requests into SETUP/ACCESS
// transfers and returns data plus status on a registered response channel.
module apb_master_bridge
    import apb_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  REQ_VALID,
    output logic                  REQ_READY,
    input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
    input  logic                  REQ_WRITE,
    input  logic [DATA_WIDTH-1:0] REQ_WDATA,
    output logic                  RSP_VALID,
    input  logic                  RSP_READY,
    output logic [DATA_WIDTH-1:0] RSP_RDATA,
    output logic [STATUS_W-1:0]   RSP_STATUS,
    output logic [ADDR_WIDTH-1:0] MASTER_PADDR,
    output logic                  MASTER_PSEL,
    output logic                  MASTER_PENABLE,
    output logic                  MASTER_PWRITE,
    output logic [DATA_WIDTH-1:0] MASTER_PWDATA,
    input  logic [DATA_WIDTH-1:0] MASTER_PRDATA,
    input  logic                  MASTER_PREADY,
    input  logic                  MASTER_PSLVERR,
    output logic [1:0]            state_dbg
);

    localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    state_t                state_q, state_d;
    logic                  load_req, load_rsp, expired;
    logic [DATA_WIDTH-1:0] rdata_d;
    logic [STATUS_W-1:0]   status_d;

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // a raised valid holds its payload stable until that edge.
    assign REQ_READY = (state_q == IDLE) && !PRESET;
    assign state_dbg = state_q;

    apb_wait_timer #(.W(CNT_W)) u_timer (
        .clk      (PCLK),
        .rst      (PRESET),
        .clear    (state_q != ACCESS),
        .count_en ((state_q == ACCESS) && !MASTER_PREADY),
        .limit    (CNT_W'(TIMEOUT_CYCLES)),
        .expired  (expired)
    );

    always_comb begin
        state_d  = state_q;
        load_req = 1'b0;
        load_rsp = 1'b0;
        rdata_d  = '0;
        status_d = ST_OK;
        case (state_q)
            IDLE: begin
                if (REQ_VALID) begin
                    if (REQ_ADDR[1:0] != 2'b00) begin
                        state_d  = RESP;
                        load_rsp = 1'b1;
                        status_d = ST_MISALIGN;
                    end else begin
                        state_d  = SETUP;
                        load_req = 1'b1;
                    end
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                // PREADY takes priority over a timeout landing on the same edge.
                if (MASTER_PREADY) begin
                    state_d  = RESP;
                    load_rsp = 1'b1;
                    status_d = MASTER_PSLVERR ? ST_SLVERR : ST_OK;
                    if (!MASTER_PWRITE && !MASTER_PSLVERR) rdata_d = MASTER_PRDATA;
                end else if (expired) begin
                    state_d  = RESP;
                    load_rsp = 1'b1;
                    status_d = ST_TIMEOUT;
                end
            end
            RESP: if (RSP_READY) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q        <= IDLE;
            MASTER_PSEL    <= 1'b0;
            MASTER_PENABLE <= 1'b0;
            MASTER_PADDR   <= '0;
            MASTER_PWRITE  <= 1'b0;
            MASTER_PWDATA  <= '0;
            RSP_VALID      <= 1'b0;
            RSP_RDATA      <= '0;
            RSP_STATUS     <= ST_OK;
        end else begin
            state_q        <= state_d;
            MASTER_PSEL    <= (state_d == SETUP) || (state_d == ACCESS);
            MASTER_PENABLE <= (state_d == ACCESS);
            RSP_VALID      <= (state_d == RESP);
            if (load_req) begin
                MASTER_PADDR  <= REQ_ADDR;
                MASTER_PWRITE <= REQ_WRITE;
                MASTER_PWDATA <= REQ_WRITE ? REQ_WDATA : '0;
            end
            if (load_rsp) begin
                RSP_RDATA  <= rdata_d;
                RSP_STATUS <= status_d;
            end
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: vector table of single transfers plus
// hand-written reset-during-ACCESS sequence.
module tb_apb_master_bridge;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        REQ_VALID, REQ_READY, REQ_WRITE;
    logic [31:0] REQ_ADDR, REQ_WDATA;
    logic        RSP_VALID, RSP_READY;
    logic [31:0] RSP_RDATA;
    logic [1:0]  RSP_STATUS;
    logic [31:0] MASTER_PADDR, MASTER_PWDATA, MASTER_PRDATA;
    logic        MASTER_PSEL, MASTER_PENABLE, MASTER_PWRITE;
    logic        MASTER_PREADY, MASTER_PSLVERR;
    logic [1:0]  state_dbg;

    int total = 0;
    int bad   = 0;

    apb_master_bridge #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_ADDR(REQ_ADDR),
        .REQ_WRITE(REQ_WRITE), .REQ_WDATA(REQ_WDATA),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RDATA(RSP_RDATA),
        .RSP_STATUS(RSP_STATUS),
        .MASTER_PADDR(MASTER_PADDR), .MASTER_PSEL(MASTER_PSEL),
        .MASTER_PENABLE(MASTER_PENABLE), .MASTER_PWRITE(MASTER_PWRITE),
        .MASTER_PWDATA(MASTER_PWDATA), .MASTER_PRDATA(MASTER_PRDATA),
        .MASTER_PREADY(MASTER_PREADY), .MASTER_PSLVERR(MASTER_PSLVERR),
        .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 PCLK = ~PCLK;

    initial begin
        #200000;
        $display("FAIL watchdog act=running req=finished");
        $fatal(1);
    end

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        int          waits;      // ACCESS cycles with PREADY low; 255 = never ready
        logic [31:0] prdata;
        logic        slverr;
        logic [1:0]  exp_status;
        logic [31:0] exp_rdata;
        int          exp_lat;    // cycles from accept edge to RSP_VALID
        int          exp_psel;   // cycles with PSEL high
        int          hold;       // cycles RSP_READY held low
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s act=%h req=%h", name, act, req);
        end
    endtask

    task automatic do_reset();
        PRESET = 1'b1;
        @(negedge PCLK);
        @(negedge PCLK);
        PRESET = 1'b0;
        @(negedge PCLK);
    endtask

    // driver plus completer model for one transfer; sampling on negedges
    task automatic run_txn(input vec_t v);
        int lat, psel_cnt, first_psel, first_pen, acc;
        bit got, stable_ok, hold_ok;
        logic [31:0] exp_pwdata;
        exp_pwdata = v.write ? v.wdata : 32'h0;
        got = 0; lat = 0; psel_cnt = 0; first_psel = -1; first_pen = -1;
        acc = 0; stable_ok = 1; hold_ok = 1;

        @(negedge PCLK);
        check("req_ready_idle", {31'h0, REQ_READY}, 32'h1);
        REQ_VALID = 1'b1; REQ_ADDR = v.addr; REQ_WRITE = v.write; REQ_WDATA = v.wdata;
        @(negedge PCLK);
        REQ_VALID = 1'b0; REQ_ADDR = $urandom; REQ_WDATA = $urandom;
        REQ_WRITE = 1'($urandom_range(0, 1));

        for (int k = 1; k <= 40 && !got; k++) begin
            if (k > 1) @(negedge PCLK);
            if (RSP_VALID) begin
                got = 1; lat = k;
                MASTER_PREADY = 1'b0; MASTER_PSLVERR = 1'b0;
            end else begin
                if (MASTER_PSEL) begin
                    psel_cnt++;
                    if (first_psel < 0) first_psel = k;
                    if (MASTER_PADDR !== v.addr || MASTER_PWRITE !== v.write ||
                        MASTER_PWDATA !== exp_pwdata) stable_ok = 0;
                end
                if (MASTER_PENABLE) begin
                    if (first_pen < 0) first_pen = k;
                    if (acc == v.waits) begin
                        MASTER_PREADY = 1'b1; MASTER_PRDATA = v.prdata; MASTER_PSLVERR = v.slverr;
                    end else begin
                        MASTER_PREADY = 1'b0; MASTER_PRDATA = $urandom;
                        MASTER_PSLVERR = 1'($urandom_range(0, 1));
                    end
                    acc++;
                end else begin
                    MASTER_PREADY = 1'($urandom_range(0, 1));
                    MASTER_PSLVERR = 1'b0; MASTER_PRDATA = $urandom;
                end
            end
        end

        check("rsp_seen", {31'h0, got}, 32'h1);
        if (!got) begin
            do_reset();
        end else begin
            check("latency", lat, v.exp_lat);
            check("status", {30'h0, RSP_STATUS}, {30'h0, v.exp_status});
            check("rdata", RSP_RDATA, v.exp_rdata);
            check("psel_cycles", psel_cnt, v.exp_psel);
            check("apb_stable", {31'h0, stable_ok}, 32'h1);
            check("apb_idle_in_resp", {30'h0, MASTER_PSEL, MASTER_PENABLE}, 32'h0);
            if (v.exp_psel > 0) begin
                check("first_psel", first_psel, 1);
                check("first_penable", first_pen, 2);
            end
            for (int h = 0; h < v.hold; h++) begin
                REQ_VALID = 1'b1; REQ_ADDR = 32'h4000_0100; REQ_WRITE = 1'b0;
                @(negedge PCLK);
                if (!RSP_VALID || RSP_RDATA !== v.exp_rdata || RSP_STATUS !== v.exp_status ||
                    REQ_READY !== 1'b0 || MASTER_PSEL !== 1'b0) hold_ok = 0;
            end
            if (v.hold > 0) check("rsp_hold", {31'h0, hold_ok}, 32'h1);
            RSP_READY = 1'b1;
            @(negedge PCLK);
            RSP_READY = 1'b0; REQ_VALID = 1'b0;
            check("rsp_valid_fall", {31'h0, RSP_VALID}, 32'h0);
            check("req_ready_back", {31'h0, REQ_READY}, 32'h1);
        end
    endtask

    initial begin
        bit no_rsp;
        vecs[0] = '{32'h4000_0010, 1'b0, 32'h0,         0,   32'hDEAD_BEEF, 1'b0, 2'b00, 32'hDEAD_BEEF, 3, 2, 0};
        vecs[1] = '{32'h4000_0004, 1'b1, 32'h1234_5678, 3,   32'hAAAA_5555, 1'b0, 2'b00, 32'h0,         6, 5, 0};
        vecs[2] = '{32'h4000_0008, 1'b0, 32'h0,         1,   32'h7777_8888, 1'b1, 2'b01, 32'h0,         4, 3, 1};
        vecs[3] = '{32'h4000_0020, 1'b0, 32'h0,         255, 32'h0,         1'b0, 2'b10, 32'h0,         6, 5, 0};
        vecs[4] = '{32'h4000_0024, 1'b0, 32'h0,         3,   32'hCAFE_F00D, 1'b0, 2'b00, 32'hCAFE_F00D, 6, 5, 0};
        vecs[5] = '{32'h4000_0002, 1'b0, 32'h0,         0,   32'h0,         1'b0, 2'b11, 32'h0,         1, 0, 5};
        vecs[6] = '{32'h4000_000C, 1'b1, 32'hA5A5_0F0F, 0,   32'h0,         1'b1, 2'b01, 32'h0,         3, 2, 0};
        vecs[7] = '{32'h4000_0001, 1'b1, 32'h0BAD_0BAD, 0,   32'h0,         1'b0, 2'b11, 32'h0,         1, 0, 2};
        vecs[8] = '{32'h4000_0FFC, 1'b0, 32'h0,         2,   32'h0000_0001, 1'b0, 2'b00, 32'h0000_0001, 5, 4, 0};

        PRESET = 1'b1; REQ_VALID = 1'b0; REQ_ADDR = '0; REQ_WRITE = 1'b0; REQ_WDATA = '0;
        RSP_READY = 1'b0; MASTER_PRDATA = '0; MASTER_PREADY = 1'b0; MASTER_PSLVERR = 1'b0;
        @(negedge PCLK);
        @(negedge PCLK);
        check("rst_ctrl", {26'h0, REQ_READY, RSP_VALID, MASTER_PSEL, MASTER_PENABLE,
                           MASTER_PWRITE, 1'b0}, 32'h0);
        check("rst_paddr", MASTER_PADDR, 32'h0);
        check("rst_pwdata", MASTER_PWDATA, 32'h0);
        check("rst_rsp", RSP_RDATA | {30'h0, RSP_STATUS}, 32'h0);
        check("rst_state", {30'h0, state_dbg}, 32'h0);
        PRESET = 1'b0;
        @(negedge PCLK);

        for (int i = 0; i < 9; i++) run_txn(vecs[i]);

        // reset while ACCESS is stalled on PREADY low
        @(negedge PCLK);
        REQ_VALID = 1'b1; REQ_ADDR = 32'h4000_0030; REQ_WRITE = 1'b0;
        @(negedge PCLK);
        REQ_VALID = 1'b0; MASTER_PREADY = 1'b0;
        @(negedge PCLK);
        @(negedge PCLK);
        check("pre_rst_penable", {31'h0, MASTER_PENABLE}, 32'h1);
        #2 PRESET = 1'b1;
        #1 check("async_rst_apb", {28'h0, MASTER_PSEL, MASTER_PENABLE, RSP_VALID, REQ_READY}, 32'h0);
        @(negedge PCLK);
        PRESET = 1'b0;
        no_rsp = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge PCLK);
            if (RSP_VALID || MASTER_PSEL) no_rsp = 0;
        end
        check("no_rsp_after_rst", {31'h0, no_rsp}, 32'h1);
        run_txn(vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
